// File: rtl/lsq_retire_queue.sv
// Retire-decision queue: buffers LSQ retire bundles, decodes the head bundle into per-slot retire vectors.
// One-cycle retire latency (registered outputs); a full queue drops pushes unless a pop frees a slot, and latches sticky ovf.
module lsq_retire_queue #(
    parameter int LANES = 6,
    parameter int SLOTS = 10,
    parameter int DEPTH = 4,
    parameter int IIW   = 6,
    parameter int EXW   = 4,
    parameter int SHRW  = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_en,
    input  logic [LANES-1:0]      in_ret_mask,
    input  logic [LANES-1:0]      in_excpt,
    input  logic [LANES-1:0]      in_ld_confl,
    input  logic [LANES-1:0]      in_wait_confl,
    input  logic [4*LANES-1:0]    in_slot,
    input  logic [EXW*LANES-1:0]  in_exbits,
    input  logic [IIW-1:0]        in_II,
    input  logic                  in_thread,
    input  logic [SHRW-1:0]       in_shr,
    output logic                  in_full,
    input  logic [IIW-1:0]        cntrl_II,
    input  logic                  doRetire,
    input  logic                  bStall,
    input  logic                  except,
    input  logic                  except_thread,
    output logic                  retire_valid,
    output logic [SLOTS-1:0]      retire_en,
    output logic [SLOTS-1:0]      retire_fine,
    output logic [SLOTS-1:0]      retire_ldconfl,
    output logic [SLOTS-1:0]      retire_waitconfl,
    output logic [SLOTS-1:0]      retire_except,
    output logic [EXW*SLOTS-1:0]  retire_exbits,
    output logic [IIW-1:0]        retire_II,
    output logic                  retire_thread,
    output logic [SHRW-1:0]       retire_shr,
    output logic [IIW-1:0]        head_II,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  ovf
);

    typedef struct packed {
        logic [LANES-1:0]     ret_mask;
        logic [LANES-1:0]     excpt;
        logic [LANES-1:0]     ld_confl;
        logic [LANES-1:0]     wait_confl;
        logic [4*LANES-1:0]   slot;
        logic [EXW*LANES-1:0] exbits;
        logic [IIW-1:0]       ii;
        logic                 thread;
        logic [SHRW-1:0]      shr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] live;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    entry_t head;
    logic   full;
    logic   retire_pop;
    logic   drain_pop;
    logic   pop;
    logic   push;
    entry_t in_entry;

    assign head    = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign in_full = full;
    assign head_II = empty ? '0 : head.ii;

    assign retire_pop = !empty && live[rd_ptr] && doRetire && !bStall && !except
                        && (cntrl_II == head.ii);
    assign drain_pop  = !empty && !live[rd_ptr];
    assign pop        = retire_pop || drain_pop;
    assign push       = in_en && (!full || pop);

    assign in_entry = '{ret_mask:   in_ret_mask,
                        excpt:      in_excpt,
                        ld_confl:   in_ld_confl,
                        wait_confl: in_wait_confl,
                        slot:       in_slot,
                        exbits:     in_exbits,
                        ii:         in_II,
                        thread:     in_thread,
                        shr:        in_shr};

    // Payload storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (except) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].thread == except_thread) begin
                        live[i] <= 1'b0;
                    end
                end
            end
            // Written last so a same-cycle flush marks the new entry dead on arrival.
            if (push) begin
                live[wr_ptr] <= !(except && (in_thread == except_thread));
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (in_en && full && !pop) begin
                ovf <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    logic [SLOTS-1:0]     dec_en;
    logic [SLOTS-1:0]     dec_except;
    logic [SLOTS-1:0]     dec_ld;
    logic [SLOTS-1:0]     dec_wait;
    logic [EXW*SLOTS-1:0] dec_exbits;
    logic                 hit;

    // Slot indices at or above SLOTS never match any k, so those lanes drop out.
    always_comb begin
        dec_en     = '0;
        dec_except = '0;
        dec_ld     = '0;
        dec_wait   = '0;
        dec_exbits = '0;
        hit        = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            for (int j = 0; j < LANES; j++) begin
                hit = head.ret_mask[j] && (head.slot[4*j +: 4] == 4'(k));
                dec_en[k]     = dec_en[k]     | hit;
                dec_except[k] = dec_except[k] | (hit & head.excpt[j]);
                dec_ld[k]     = dec_ld[k]     | (hit & head.ld_confl[j]);
                dec_wait[k]   = dec_wait[k]   | (hit & head.wait_confl[j]);
                dec_exbits[EXW*k +: EXW] = dec_exbits[EXW*k +: EXW]
                                         | (head.exbits[EXW*j +: EXW] & {EXW{hit}});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !retire_pop) begin
            retire_valid     <= 1'b0;
            retire_en        <= '0;
            retire_fine      <= '0;
            retire_ldconfl   <= '0;
            retire_waitconfl <= '0;
            retire_except    <= '0;
            retire_exbits    <= '0;
            retire_II        <= '0;
            retire_thread    <= 1'b0;
            retire_shr       <= '0;
        end else begin
            retire_valid     <= 1'b1;
            retire_en        <= dec_en;
            retire_fine      <= dec_en & ~dec_except & ~dec_ld & ~dec_wait;
            retire_ldconfl   <= dec_ld;
            retire_waitconfl <= dec_wait;
            retire_except    <= dec_except;
            retire_exbits    <= dec_exbits;
            retire_II        <= head.ii;
            retire_thread    <= head.thread;
            retire_shr       <= head.shr;
        end
    end

endmodule

// File: doc/lsq_retire_queue.md
# lsq_retire_queue

Parametrised retire-decision queue for the load/store queue. It buffers up to DEPTH retire bundles of LANES lanes each. Each lane carries a retire mask, a slot index, and exception, load-conflict and wait-conflict flags with exception bits. When the retire controller's II matches the head bundle, the queue decodes the head into per-slot retire vectors for SLOTS retire slots. Sits between the LSQ bundle-check logic and the retire unit; adds buffering, per-thread exception flush and registered outputs.

## Interface
- LANES, 6, lanes per bundle
- SLOTS, 10, retire slots decoded (≤16)
- DEPTH, 4, bundle entries (power of 2, ≥2)
- IIW, 6, bundle II width
- EXW, 4, exception bits per lane
- SHRW, 8, shared-data width carried per bundle
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_en  in  1  push request
- in_ret_mask, in_excpt, in_ld_confl, in_wait_confl  in  LANES each  per-lane flags
- in_slot  in  4*LANES  lane slot index, lane j at [4j+:4]
- in_exbits  in  EXW*LANES  lane exception bits, lane j at [EXW*j+:EXW]
- in_II  in  IIW  bundle II
- in_thread  in  1  bundle thread
- in_shr  in  SHRW  shared data
- in_full  out  1  count==DEPTH (combinational)
- cntrl_II  in  IIW  II the retire unit wants
- doRetire  in  1  retire permitted
- bStall  in  1  retire stall
- except  in  1  flush request
- except_thread  in  1  thread to flush
- retire_valid  out  1  registered retire outputs valid
- retire_en, retire_fine, retire_ldconfl, retire_waitconfl, retire_except  out  SLOTS each  per-slot results
- retire_exbits  out  EXW*SLOTS  per-slot exception bits
- retire_II  out  IIW; retire_thread  out  1; retire_shr  out  SHRW  head-entry fields
- head_II  out  IIW  II of head entry (0 when empty)
- empty  out  1; count  out  $clog2(DEPTH+1)
- ovf  out  1  sticky overflow

## Operation
- Circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap) and count. Each entry holds all in_* fields plus a live bit.
- Push: in_en && (count<DEPTH || pop). The entry is written at wr_ptr with live=1. If in_en && full && !pop, the bundle is dropped and ovf is set; ovf is cleared only by rst.
- Retire pop: count!=0 && live[head] && doRetire && !bStall && !except && cntrl_II==head_II.
- Drain pop: count!=0 && !live[head]. Dead entries are removed silently, one per cycle, with no retire output.
- pop = retire pop | drain pop. Simultaneous push and pop leaves count unchanged.
- Flush: when except=1, every stored entry with thread==except_thread gets live=0 that cycle. An entry pushed in the same cycle with in_thread==except_thread is written with live=0. Except blocks retire pop in that cycle; a drain pop still proceeds.
- Slot decode for the head entry, slot k, lane j with m_j = ret_mask[j] && slot[j]==k:
  - en_k = OR_j m_j
  - except_k = OR_j (m_j && excpt[j])
  - ld_k = OR_j (m_j && ld_confl[j])
  - wait_k = OR_j (m_j && wait_confl[j])
  - fine_k = en_k && !except_k && !ld_k && !wait_k
  - exbits_k = OR_j (exbits_j & {EXW{m_j}})
- Lanes with slot ≥ SLOTS are ignored.
- Output register:
  - Cycle after a retire pop: retire_valid=1, vectors and fields from the popped entry.
  - Otherwise: retire_valid=0 and all retire_* outputs 0.

## Timing
- Reset values: retire_* all 0, retire_valid=0, count=0, empty=1, head_II=0, in_full=0, ovf=0; pointers 0; all live bits 0.
- Push at edge N is visible on head_II, empty and count after edge N, so a retire pop is possible in cycle N+1.
- Retire latency is 1 cycle: pop decided in cycle N, retire_valid high in cycle N+1.
- Throughput is one pop per cycle, retire or drain.
- in_full, empty, count and head_II come straight from registers; there is no combinational path from cntrl_II to them.
- rst mid-operation discards all entries; outputs return to reset values on the next edge.

## Test plan
- Reset, then push II=5, lanes 0 and 1 mask=1, slots 2 and 2, lane1 ld_confl=1. Set cntrl_II=5, doRetire=1 -> one cycle later retire_valid=1, retire_en=0x004, retire_ldconfl=0x004, retire_fine=0; count returns to 0.
- Fill 4 entries (II=1..4) with no retire; push a fifth -> in_full=1, fifth dropped, ovf=1. Push again in the same cycle as a retire pop of II=1 -> accepted, count stays 4.
- Queue holds II=1 (thread0), II=2 (thread1), II=3 (thread0); pulse except with except_thread=0 -> II=1 drained silently, II=2 at head next cycle, retire of II=2 works, II=3 drained; no retire_valid for thread0 entries.
- Head II=7 with cntrl_II=7, doRetire=1 and bStall=1 for 3 cycles -> no pop, retire_valid=0; bStall drops -> retire in the following cycle.
- Lane slot=12 with SLOTS=10, plus lane slot=0 with excpt=1 and exbits=0xA -> retire_en=0x001, retire_except=0x001, retire_exbits[3:0]=0xA, slot 12 ignored.
- Wrap-around: 10 push/retire pairs back-to-back at 1 per cycle -> all 10 retire in order, count never exceeds 1, pointers wrap cleanly.
